// File: rtl/ps2_key_tracker.sv
// Key-state tracker for decoded PS/2 scancodes: per-slot held level, press/release
// pulses, typematic auto-repeat for the most recently pressed slot, held-key count.
module ps2_key_tracker #(
  parameter int                    NUM_KEYS      = 6,
  parameter logic [9*NUM_KEYS-1:0] RESET_TABLE   = {9'h023, 9'h01B, 9'h01D, 9'h172, 9'h175, 9'h16B},
  parameter int                    CNT_W         = 24,
  parameter logic [CNT_W-1:0]      REPEAT_DELAY  = 24'd12_500_000,
  parameter logic [CNT_W-1:0]      REPEAT_PERIOD = 24'd2_500_000,
  parameter bit                    REPEAT_EN     = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            code_valid,
  input  logic [9:0]                      code,
  input  logic                            cfg_we,
  input  logic [4:0]                      cfg_idx,
  input  logic [8:0]                      cfg_code,
  output logic [NUM_KEYS-1:0]             key_state,
  output logic [NUM_KEYS-1:0]             key_press,
  output logic [NUM_KEYS-1:0]             key_release,
  output logic [NUM_KEYS-1:0]             repeat_pulse,
  output logic [$clog2(NUM_KEYS+1)-1:0]   held_count,
  output logic                            any_key
);

  localparam int HC_W  = $clog2(NUM_KEYS + 1);
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic [8:0]          slot_tab [NUM_KEYS];
  logic [NUM_KEYS-1:0] match;
  logic [NUM_KEYS-1:0] wr_hit;
  logic [NUM_KEYS-1:0] press_n;
  logic [NUM_KEYS-1:0] release_n;
  logic [NUM_KEYS-1:0] state_n;
  logic [HC_W-1:0]     count_n;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    match     = '0;
    wr_hit    = '0;
    press_n   = '0;
    release_n = '0;
    state_n   = key_state;
    count_n   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match[i]  = code_valid && (slot_tab[i] == code[8:0]);
      wr_hit[i] = cfg_we && (int'(cfg_idx) == i);
    end
    // Matching sees the pre-write table entry; a same-cycle write then clears that slot silently.
    if (code[9]) begin
      release_n = match & key_state & ~wr_hit;
      state_n   = key_state & ~match & ~wr_hit;
    end else begin
      press_n   = match & ~key_state & ~wr_hit;
      state_n   = (key_state | match) & ~wr_hit;
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      count_n = count_n + HC_W'(state_n[i]);
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
      held_count  <= '0;
      any_key     <= 1'b0;
      // NOTE: the slot table is a small register file that must come up loaded, so it is reset.
      for (int i = 0; i < NUM_KEYS; i++) begin
        slot_tab[i] <= RESET_TABLE[9*i +: 9];
      end
    end else begin
      key_state   <= state_n;
      key_press   <= press_n;
      key_release <= release_n;
      held_count  <= count_n;
      any_key     <= |state_n;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (wr_hit[i]) slot_tab[i] <= cfg_code;
      end
    end
  end

  if (REPEAT_EN) begin : g_repeat
    typedef enum logic [1:0] {REP_IDLE, REP_DELAY, REP_REPEAT} rep_state_t;

    rep_state_t          rep_state;
    logic [CNT_W-1:0]    rep_cnt;
    logic [IDX_W-1:0]    rep_idx;
    logic                press_any;
    logic [IDX_W-1:0]    press_idx;
    logic [NUM_KEYS-1:0] drop_vec;
    logic                rep_drop;

    // Lowest pressed index wins when several slots press together.
    always_comb begin
      press_any = 1'b0;
      press_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
        if (press_n[i]) begin
          press_any = 1'b1;
          press_idx = IDX_W'(i);
        end
      end
      drop_vec = release_n | wr_hit;
      rep_drop = drop_vec[rep_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rep_state    <= REP_IDLE;
        rep_cnt      <= '0;
        rep_idx      <= '0;
        repeat_pulse <= '0;
      end else begin
        repeat_pulse <= '0;
        if (press_any) begin
          rep_idx   <= press_idx;
          rep_cnt   <= '0;
          rep_state <= REP_DELAY;
        end else if (rep_state != REP_IDLE && rep_drop) begin
          rep_cnt   <= '0;
          rep_state <= REP_IDLE;
        end else begin
          case (rep_state)
            REP_DELAY: begin
              if (rep_cnt == REPEAT_DELAY - CNT_W'(1)) begin
                repeat_pulse[rep_idx] <= 1'b1;
                rep_cnt               <= '0;
                rep_state             <= REP_REPEAT;
              end else begin
                rep_cnt <= rep_cnt + CNT_W'(1);
              end
            end
            REP_REPEAT: begin
              if (rep_cnt == REPEAT_PERIOD - CNT_W'(1)) begin
                repeat_pulse[rep_idx] <= 1'b1;
                rep_cnt               <= '0;
              end else begin
                rep_cnt <= rep_cnt + CNT_W'(1);
              end
            end
            default: rep_cnt <= '0;
          endcase
        end
      end
    end
  end else begin : g_no_repeat
    assign repeat_pulse = '0;
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed plan steps plus random traffic, checked against
// a slot/held-set model with repeat timing computed from the age of the latest press.
module tb_ps2_key_tracker;

  localparam int          NK  = 6;
  localparam int          D   = 10;
  localparam int          P   = 4;
  localparam logic [53:0] RT  = {9'h023, 9'h01B, 9'h01D, 9'h172, 9'h175, 9'h16B};

  logic        clk = 1'b0;
  logic        rst;
  logic        code_valid;
  logic [9:0]  code;
  logic        cfg_we;
  logic [4:0]  cfg_idx;
  logic [8:0]  cfg_code;
  logic [5:0]  key_state, key_press, key_release, repeat_pulse;
  logic [2:0]  held_count;
  logic        any_key;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [8:0] m_tab [NK];
  logic [5:0] m_held, e_press, e_rel, e_rep;
  bit         m_active;
  int         m_key, m_age;

  ps2_key_tracker #(
    .NUM_KEYS(NK), .RESET_TABLE(RT), .CNT_W(24),
    .REPEAT_DELAY(24'd10), .REPEAT_PERIOD(24'd4), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_code(cfg_code),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .repeat_pulse(repeat_pulse), .held_count(held_count), .any_key(any_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NK; i++) m_tab[i] = RT[9*i +: 9];
    m_held = '0; e_press = '0; e_rel = '0; e_rep = '0;
    m_active = 1'b0; m_key = 0; m_age = 0;
  endtask

  task automatic model_edge(input bit v, input logic [9:0] c, input bit we,
                            input logic [4:0] ix, input logic [8:0] cc);
    logic [5:0] nxt, written;
    nxt = m_held; written = '0;
    e_press = '0; e_rel = '0; e_rep = '0;
    for (int i = 0; i < NK; i++) begin
      if (v && m_tab[i] == c[8:0]) begin
        if (!c[9] && !m_held[i]) begin nxt[i] = 1'b1; e_press[i] = 1'b1; end
        if (c[9] && m_held[i])   begin nxt[i] = 1'b0; e_rel[i]   = 1'b1; end
      end
    end
    for (int i = 0; i < NK; i++) begin
      if (we && int'(ix) == i) begin
        nxt[i] = 1'b0; e_press[i] = 1'b0; e_rel[i] = 1'b0;
        m_tab[i] = cc; written[i] = 1'b1;
      end
    end
    m_held = nxt;
    if (e_press != 0) begin
      for (int i = NK - 1; i >= 0; i--) if (e_press[i]) m_key = i;
      m_active = 1'b1; m_age = 0;
    end else if (m_active && (e_rel[m_key] || written[m_key])) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_age++;
      if (m_age >= D && (m_age - D) % P == 0) e_rep[m_key] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},   32'(key_state),    32'(m_held));
    chk({tag, ".press"},   32'(key_press),    32'(e_press));
    chk({tag, ".release"}, 32'(key_release),  32'(e_rel));
    chk({tag, ".repeat"},  32'(repeat_pulse), 32'(e_rep));
    chk({tag, ".count"},   32'(held_count),   32'($countones(m_held)));
    chk({tag, ".any"},     32'(any_key),      32'(m_held != 0));
  endtask

  task automatic tick(input string tag, input bit v, input logic [9:0] c,
                      input bit we = 1'b0, input logic [4:0] ix = 5'd0,
                      input logic [8:0] cc = 9'd0);
    code_valid = v; code = c; cfg_we = we; cfg_idx = ix; cfg_code = cc;
    @(posedge clk);
    model_edge(v, c, we, ix, cc);
    #1;
    // Junk on code while code_valid is low must be ignored.
    code_valid = 1'b0; cfg_we = 1'b0;
    code = 10'($urandom); cfg_idx = 5'($urandom); cfg_code = 9'($urandom);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) tick(tag, 1'b0, 10'h000);
  endtask

  initial begin
    rst = 1'b1; code_valid = 1'b0; code = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_code = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Left make then break
    tick("left_make", 1'b1, 10'h16B);
    chk("left_state_const", 32'(key_state), 32'h01);
    idle("left_hold", 1);
    tick("left_break", 1'b1, 10'h36B);
    idle("left_idle", 2);

    // Typematic makes and duplicate breaks on W
    tick("w_make1", 1'b1, 10'h01D);
    idle("w_gap", 5);
    tick("w_make2", 1'b1, 10'h01D);
    chk("w_no_second_press", 32'(key_press), 32'h00);
    tick("w_break1", 1'b1, 10'h21D);
    tick("w_break2", 1'b1, 10'h21D);
    idle("w_idle", 2);

    // Repeat timing: pulses at 10, 14, 18 after press
    tick("rep_make", 1'b1, 10'h01D);
    idle("rep_hold", 20);
    tick("rep_break", 1'b1, 10'h21D);
    idle("rep_after", 10);

    // Retarget to D after 6 cycles, release W, D keeps repeating
    tick("rt_w", 1'b1, 10'h01D);
    idle("rt_gap", 5);
    tick("rt_d", 1'b1, 10'h023);
    idle("rt_hold", 12);
    tick("rt_w_break", 1'b1, 10'h21D);
    idle("rt_d_cont", 10);
    tick("rt_d_break", 1'b1, 10'h223);

    // Unextended code, same-cycle config write
    tick("unext", 1'b1, 10'h06B);
    tick("cfg_same", 1'b1, 10'h06B, 1'b1, 5'd0, 9'h06B);
    tick("cfg_next", 1'b1, 10'h06B);
    chk("cfg_slot0_set", 32'(key_state[0]), 32'd1);

    // Out-of-range cfg writes ignored; write of repeat slot stops repeat
    tick("cfg_oob6", 1'b0, 10'h000, 1'b1, 5'd6, 9'h01D);
    tick("cfg_oob31", 1'b0, 10'h000, 1'b1, 5'd31, 9'h01D);
    tick("wr_rep_make", 1'b1, 10'h01D);
    idle("wr_rep_gap", 3);
    tick("wr_rep_cfg", 1'b0, 10'h000, 1'b1, 5'd3, 9'h01D);
    idle("wr_rep_idle", 14);
    tick("wr_rep_again", 1'b1, 10'h01D);

    // Async reset with keys held and repeat active
    tick("mr_up", 1'b1, 10'h175);
    tick("mr_down", 1'b1, 10'h172);
    idle("mr_hold", 11);
    rst = 1'b1;
    #2;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
    tick("rst_table", 1'b1, 10'h16B);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int          sel;
      logic [9:0]  c;
      bit          we;
      logic [4:0]  ix;
      logic [8:0]  cc;
      sel   = $urandom_range(0, 7);
      c[8:0] = (sel < NK) ? m_tab[sel] : 9'($urandom);
      c[9]  = ($urandom_range(0, 2) == 0);
      we    = ($urandom_range(0, 19) == 0);
      ix    = 5'($urandom_range(0, 7));
      sel   = $urandom_range(0, 7);
      cc    = (sel < NK) ? m_tab[sel] : 9'($urandom);
      tick("rand", $urandom_range(0, 1) == 1, c, we, ix, cc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
